// File: rtl/cordic_arbiter.sv
// Round-robin arbiter that time-shares one CORDIC core among 2**IDW angle requesters.
// Optional WAIT watchdog enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter #(
    parameter int             IDW      = 2,
    parameter int             DW       = 16,
    parameter logic [DW-1:0]  X_INIT   = DW'(16'h26DD),
    parameter int             LOAD_CYC = 2,
    parameter int             TIMEOUT  = 64,
    localparam int            NREQ     = 2**IDW
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [NREQ-1:0]      req_val,
    input  logic [NREQ*DW-1:0]   req_theta,
    output logic [NREQ-1:0]      req_rdy,
    output logic                 core_rst,
    output logic [DW-1:0]        core_x_in,
    output logic [DW-1:0]        core_y_in,
    output logic [DW-1:0]        core_theta_in,
    output logic                 core_operands_val,
    output logic                 core_ack,
    input  logic [DW-1:0]        core_x_out,
    input  logic [DW-1:0]        core_y_out,
    input  logic                 core_out_valid,
    output logic                 rsp_val,
    input  logic                 rsp_rdy,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_cos,
    output logic [DW-1:0]        rsp_sin,
    output logic                 rsp_err,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_LOAD = 3'd2,
        S_WAIT = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam int LCW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

    state_t          st;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  cand;
    logic            gnt_any;
    logic [IDW-1:0]  gnt_q;
    logic [DW-1:0]   theta_q;
    logic [LCW-1:0]  load_cnt;

    assign state = st;

    // Scan downward in priority so the candidate closest to rr_ptr is written last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = rr_ptr;
        cand    = rr_ptr;
        for (int k = NREQ-1; k >= 0; k--) begin
            cand = rr_ptr + IDW'(k);
            if (req_val[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Grant must be visible in the same cycle the request is seen; masked by Rst so outputs read 0 in reset.
    assign req_rdy = (st == S_IDLE && gnt_any && !Rst) ? (NREQ'(1) << gnt_idx) : '0;

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TCW-1:0] tcnt;
    logic           err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            st                <= S_IDLE;
            rr_ptr            <= '0;
            gnt_q             <= '0;
            theta_q           <= '0;
            load_cnt          <= '0;
            core_rst          <= 1'b0;
            core_x_in         <= '0;
            core_y_in         <= '0;
            core_theta_in     <= '0;
            core_operands_val <= 1'b0;
            core_ack          <= 1'b0;
            rsp_val           <= 1'b0;
            rsp_id            <= '0;
            rsp_cos           <= '0;
            rsp_sin           <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
            tcnt              <= '0;
            err_q             <= 1'b0;
`endif
        end else begin
            case (st)
                S_IDLE: begin
                    if (gnt_any) begin
                        gnt_q    <= gnt_idx;
                        theta_q  <= req_theta[int'(gnt_idx)*DW +: DW];
                        rr_ptr   <= gnt_idx + IDW'(1);
                        core_rst <= 1'b1;
                        st       <= S_CLR;
                    end
                end
                S_CLR: begin
                    core_rst          <= 1'b0;
                    core_operands_val <= 1'b1;
                    core_ack          <= 1'b1;
                    core_x_in         <= X_INIT;
                    core_y_in         <= '0;
                    core_theta_in     <= theta_q;
                    load_cnt          <= '0;
                    st                <= S_LOAD;
                end
                S_LOAD: begin
                    if (load_cnt == LCW'(LOAD_CYC-1)) begin
                        core_operands_val <= 1'b0;
                        core_ack          <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
                        tcnt              <= '0;
`endif
                        st                <= S_WAIT;
                    end else begin
                        load_cnt <= load_cnt + LCW'(1);
                    end
                end
                S_WAIT: begin
                    if (core_out_valid) begin
                        rsp_cos <= core_x_out;
                        rsp_sin <= core_y_out;
                        rsp_id  <= gnt_q;
                        rsp_val <= 1'b1;
`ifdef CORDIC_ARB_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        st      <= S_RESP;
                    end
`ifdef CORDIC_ARB_TIMEOUT_EN
                    else if (tcnt == TCW'(TIMEOUT-1)) begin
                        rsp_cos <= '0;
                        rsp_sin <= '0;
                        rsp_id  <= gnt_q;
                        rsp_val <= 1'b1;
                        err_q   <= 1'b1;
                        st      <= S_RESP;
                    end else begin
                        tcnt <= tcnt + TCW'(1);
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_rdy) begin
                        rsp_val <= 1'b0;
                        st      <= S_IDLE;
                    end
                end
                default: begin
                    core_rst          <= 1'b0;
                    core_operands_val <= 1'b0;
                    core_ack          <= 1'b0;
                    rsp_val           <= 1'b0;
                    st                <= S_IDLE;
                end
            endcase
        end
    end

endmodule
